// File: rtl/win_framer_pkg.sv
// Shared types and default constants for the window framer.
// Ports: none (package only).
package win_pkg;

    localparam int Dwidth = 16;
    localparam int Nwin   = 32;
    localparam int Iwidth = 5;
    localparam int Nhop   = 16;

    typedef enum logic [1:0] {
        FILL,
        IDLE,
        READ
    } state_t;

    typedef struct packed {
        logic [Dwidth-1:0] re;
        logic [Dwidth-1:0] im;
    } cplx_t;

endpackage

// File: rtl/win_framer_if.sv
// Sample-stream bundle between the framer and its neighbours.
// master: drives dv_in/din_*; slave: drives dv_out/index/sof/dout_*/overflow.
interface win_framer_if #(
    parameter int Dwidth = win_pkg::Dwidth,
    parameter int Iwidth = win_pkg::Iwidth
);

    logic              dv_in;
    logic [Dwidth-1:0] din_real;
    logic [Dwidth-1:0] din_imag;
    logic              dv_out;
    logic [Iwidth-1:0] index;
    logic              sof;
    logic [Dwidth-1:0] dout_real;
    logic [Dwidth-1:0] dout_imag;
    logic              overflow;

    modport master (
        output dv_in, din_real, din_imag,
        input  dv_out, index, sof,
        input  dout_real, dout_imag, overflow
    );

    modport slave (
        input  dv_in, din_real, din_imag,
        output dv_out, index, sof,
        output dout_real, dout_imag, overflow
    );

endinterface

// File: rtl/win_framer_ram.sv
// Simple dual-port synchronous RAM, one write and one registered read port.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side (1-cycle latency).
module win_framer_ram #(
    parameter int Width  = 32,
    parameter int Depth  = 64,
    parameter int Awidth = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [Awidth-1:0] waddr,
    input  logic [Width-1:0]  wdata,
    input  logic [Awidth-1:0] raddr,
    output logic [Width-1:0]  rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/win_framer.sv
// Buffers a gappy complex stream and replays overlapping Nwin-sample frames.
// Ports: clk, rst_n (async low), bus (slave: dv_in/din_* in, dv_out/index/sof/dout_*/overflow out).
module win_framer #(
    parameter int Dwidth = win_pkg::Dwidth,
    parameter int Nwin   = win_pkg::Nwin,
    parameter int Iwidth = win_pkg::Iwidth,
    parameter int Nhop   = win_pkg::Nhop
) (
    input  logic         clk,
    input  logic         rst_n,
    win_framer_if.slave  bus
);

    import win_pkg::*;

    localparam int Awidth = Iwidth + 1;
    localparam int Depth  = 2 * Nwin;

    localparam logic [Iwidth-1:0] NWIN_LAST = Iwidth'(Nwin - 1);
    localparam logic [Iwidth-1:0] HOP_LAST  = Iwidth'(Nhop - 1);
    localparam logic [Awidth-1:0] NWIN_A    = Awidth'(Nwin);

    state_t state, state_nx;

    logic [Awidth-1:0] wp;
    logic [Awidth-1:0] wp_inc;
    logic [Awidth-1:0] trig_addr;
    logic [Iwidth-1:0] fill_cnt;
    logic [Iwidth-1:0] hop_cnt;
    logic              trig;

    logic [Awidth-1:0] base, base_nx;
    logic [Iwidth-1:0] rd_cnt, rd_cnt_nx;
    logic              pend_vld, pend_vld_nx;
    logic [Awidth-1:0] pend_addr, pend_addr_nx;
    logic              ovf_q, ovf_nx;
    logic              rd_last;
    logic [Awidth-1:0] rd_addr;

    logic [2*Dwidth-1:0] rdata;
    logic                v1;
    logic [Iwidth-1:0]   idx1;
    logic                dv_q;
    logic [Iwidth-1:0]   idx_q;
    logic                sof_q;
    logic [Dwidth-1:0]   dre_q;
    logic [Dwidth-1:0]   dim_q;

    // Start of the newest Nwin samples, counting the one being written now.
    assign wp_inc    = wp + 1'b1;
    assign trig_addr = wp_inc - NWIN_A;

    always_comb begin
        trig = 1'b0;
        if (bus.dv_in) begin
            if (state == FILL) begin
                trig = (fill_cnt == NWIN_LAST);
            end else begin
                trig = (hop_cnt == HOP_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            fill_cnt <= '0;
            hop_cnt  <= '0;
        end else if (bus.dv_in) begin
            wp <= wp_inc;
            if (state == FILL) begin
                fill_cnt <= fill_cnt + 1'b1;
                hop_cnt  <= '0;
            end else if (hop_cnt == HOP_LAST) begin
                hop_cnt <= '0;
            end else begin
                hop_cnt <= hop_cnt + 1'b1;
            end
        end
    end

    assign rd_last = (rd_cnt == NWIN_LAST);
    assign rd_addr = base + Awidth'(rd_cnt);

    always_comb begin
        state_nx     = state;
        base_nx      = base;
        rd_cnt_nx    = rd_cnt;
        pend_vld_nx  = pend_vld;
        pend_addr_nx = pend_addr;
        ovf_nx       = ovf_q;
        unique case (state)
            FILL, IDLE: begin
                if (trig) begin
                    state_nx  = READ;
                    base_nx   = trig_addr;
                    rd_cnt_nx = '0;
                end
            end
            READ: begin
                rd_cnt_nx = rd_cnt + 1'b1;
                unique case (1'b1)
                    rd_last && pend_vld: begin
                        // Chain straight into the queued frame; a trigger
                        // now has nowhere to go.
                        base_nx     = pend_addr;
                        pend_vld_nx = 1'b0;
                        if (trig) begin
                            ovf_nx = 1'b1;
                        end
                    end
                    rd_last && !pend_vld: begin
                        // A trigger on the final read is served back to back.
                        if (trig) begin
                            base_nx = trig_addr;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                    !rd_last && trig && pend_vld: begin
                        ovf_nx = 1'b1;
                    end
                    !rd_last && trig && !pend_vld: begin
                        pend_vld_nx  = 1'b1;
                        pend_addr_nx = trig_addr;
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                state_nx = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            base      <= '0;
            rd_cnt    <= '0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            base      <= base_nx;
            rd_cnt    <= rd_cnt_nx;
            pend_vld  <= pend_vld_nx;
            pend_addr <= pend_addr_nx;
            ovf_q     <= ovf_nx;
        end
    end

    win_framer_ram #(
        .Width  (2 * Dwidth),
        .Depth  (Depth),
        .Awidth (Awidth)
    ) u_ram (
        .clk   (clk),
        .we    (bus.dv_in),
        .waddr (wp),
        .wdata ({bus.din_real, bus.din_imag}),
        .raddr (rd_addr),
        .rdata (rdata)
    );

    // Stage 1 tracks the RAM read, stage 2 registers the RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            idx1  <= '0;
            dv_q  <= 1'b0;
            idx_q <= '0;
            sof_q <= 1'b0;
            dre_q <= '0;
            dim_q <= '0;
        end else begin
            v1    <= (state == READ);
            idx1  <= rd_cnt;
            dv_q  <= v1;
            idx_q <= idx1;
            sof_q <= v1 && (idx1 == '0);
            if (v1) begin
                dre_q <= rdata[2*Dwidth-1:Dwidth];
                dim_q <= rdata[Dwidth-1:0];
            end
        end
    end

    assign bus.dv_out    = dv_q;
    assign bus.index     = idx_q;
    assign bus.sof       = sof_q;
    assign bus.dout_real = dre_q;
    assign bus.dout_imag = dim_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_win_framer.sv
// Self-checking bench for win_framer (Nhop=16 and Nhop=Nwin instances).
// Ports: none (top-level bench).
module tb_win_framer;

    import win_pkg::*;

    typedef struct packed {
        logic [Iwidth-1:0] idx;
        logic              sof;
        cplx_t             s;
    } exp_t;

    typedef struct {
        int n_fast;
        int n_slow;
        bit data;
        int exp_frames;
        bit exp_ovf;
        int exp_run;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    win_framer_if #(.Dwidth(Dwidth), .Iwidth(Iwidth)) bus ();
    win_framer_if #(.Dwidth(Dwidth), .Iwidth(Iwidth)) bus2 ();

    win_framer #(
        .Dwidth(Dwidth), .Nwin(Nwin), .Iwidth(Iwidth), .Nhop(Nhop)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    win_framer #(
        .Dwidth(Dwidth), .Nwin(Nwin), .Iwidth(Iwidth), .Nhop(Nwin)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    int total = 0;
    int bad = 0;

    exp_t  q[$];
    exp_t  q2[$];
    cplx_t hist[$];
    int    n_in;
    int    n2;
    bit    chk_data;
    bit    ovf_mode;
    int    frames, frames2;
    int    run, max_run;
    int    ncyc = 0;
    int    nwr;
    int    last_wr, first_dv;
    bit    seen_ovf;
    bit    prev_v;
    logic [Iwidth-1:0] prev_idx;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic cplx_t mk(int v);
        cplx_t c;
        c.re = Dwidth'(v);
        c.im = Dwidth'(-v);
        return c;
    endfunction

    // Reference model: every Nhop samples after the first Nwin, queue a frame
    // of the newest Nwin samples.
    task automatic push_sample(int v);
        exp_t e;
        hist.push_back(mk(v));
        n_in++;
        if (chk_data && n_in >= Nwin && ((n_in - Nwin) % Nhop) == 0) begin
            for (int k = 0; k < Nwin; k++) begin
                e.idx = Iwidth'(k);
                e.sof = (k == 0);
                e.s   = hist[n_in - Nwin + k];
                q.push_back(e);
            end
        end
    endtask

    task automatic drive(bit v, int val);
        @(posedge clk);
        #1;
        bus.dv_in    = v;
        bus.din_real = mk(val).re;
        bus.din_imag = mk(val).im;
        if (v) push_sample(val);
    endtask

    task automatic drive2(bit v, int val);
        exp_t e;
        @(posedge clk);
        #1;
        bus2.dv_in    = v;
        bus2.din_real = mk(val).re;
        bus2.din_imag = mk(val).im;
        if (v) begin
            e.idx = Iwidth'(n2 % Nwin);
            e.sof = ((n2 % Nwin) == 0);
            e.s   = mk(val);
            q2.push_back(e);
            n2++;
        end
    endtask

    task automatic clear_model();
        q.delete();
        q2.delete();
        hist.delete();
        n_in     = 0;
        n2       = 0;
        frames   = 0;
        frames2  = 0;
        run      = 0;
        max_run  = 0;
        nwr      = 0;
        last_wr  = -1;
        first_dv = -1;
        seen_ovf = 1'b0;
        prev_v   = 1'b0;
        prev_idx = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.dv_in  = 1'b0;
        bus2.dv_in = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(string name);
        int w;
        w = 0;
        while ((q.size() != 0 || q2.size() != 0 || bus.dv_out || bus2.dv_out)
               && w < 500) begin
            @(posedge clk);
            w++;
        end
        check({name, "_drain"}, 64'(q.size() + q2.size()), 64'd0);
        repeat (5) @(posedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [Iwidth-1:0] want_idx;
        ncyc++;
        if (rst_n) begin
            if (bus.dv_in) begin
                nwr++;
                if (nwr == Nwin) last_wr = ncyc;
                if (ovf_mode && nwr == 2 * Nwin) check("ovf_before", bus.overflow, 1'b0);
                if (ovf_mode && nwr == 2 * Nwin + 1) check("ovf_on_drop", bus.overflow, 1'b1);
            end
            if (seen_ovf) check("ovf_sticky", bus.overflow, 1'b1);
            if (bus.overflow) seen_ovf = 1'b1;
            if (bus.dv_out) begin
                run++;
                if (run > max_run) max_run = run;
                if (first_dv < 0) first_dv = ncyc;
                if (bus.sof) frames++;
                if (chk_data) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_dv: got idx %0d want none", bus.index);
                    end else begin
                        e = q.pop_front();
                        check("sample", {bus.index, bus.sof, bus.dout_real, bus.dout_imag}, e);
                    end
                end else begin
                    want_idx = prev_v ? prev_idx + 1'b1 : '0;
                    check("idx_step", bus.index, want_idx);
                    check("sof_pos", bus.sof, bus.index == '0);
                end
                prev_idx = bus.index;
            end else begin
                run = 0;
            end
            prev_v = bus.dv_out;
            if (bus2.dv_out) begin
                if (bus2.sof) frames2++;
                if (q2.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dv2: got idx %0d want none", bus2.index);
                end else begin
                    e = q2.pop_front();
                    check("sample2", {bus2.index, bus2.sof, bus2.dout_real, bus2.dout_imag}, e);
                end
            end
        end
    end

    initial begin
        row_t rows[4];
        int   w;

        bus.dv_in    = 1'b0;
        bus.din_real = '0;
        bus.din_imag = '0;
        bus2.dv_in    = 1'b0;
        bus2.din_real = '0;
        bus2.din_imag = '0;
        chk_data = 1'b1;
        ovf_mode = 1'b0;
        clear_model();

        // n_fast, n_slow (every 2nd cycle), data check, frames, overflow, longest dv run
        rows[0] = '{32,  0, 1'b1, 1, 1'b0, 32};
        rows[1] = '{32, 32, 1'b1, 3, 1'b0, 0};
        rows[2] = '{48,  0, 1'b1, 2, 1'b0, 64};
        rows[3] = '{100, 0, 1'b0, 3, 1'b1, 96};

        for (int r = 0; r < 4; r++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            bus.dv_in = 1'b0;
            clear_model();
            #1;
            check("rst_dv", bus.dv_out, 1'b0);
            check("rst_idx", bus.index, '0);
            check("rst_sof", bus.sof, 1'b0);
            check("rst_dout", {bus.dout_real, bus.dout_imag}, '0);
            check("rst_ovf", bus.overflow, 1'b0);
            chk_data = rows[r].data;
            ovf_mode = !rows[r].data;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int i = 0; i < rows[r].n_fast; i++) drive(1'b1, i);
            for (int i = 0; i < rows[r].n_slow; i++) begin
                drive(1'b0, 0);
                drive(1'b1, rows[r].n_fast + i);
            end
            drive(1'b0, 0);
            drain("row");
            check("frames", 64'(frames), 64'(rows[r].exp_frames));
            check("ovf_final", bus.overflow, rows[r].exp_ovf);
            check("latency", 64'(first_dv - last_wr), 64'd3);
            if (rows[r].exp_run != 0) check("dv_run", 64'(max_run), 64'(rows[r].exp_run));
        end

        // Reset in the middle of a frame, then refill from fresh samples.
        ovf_mode = 1'b0;
        chk_data = 1'b1;
        do_reset();
        for (int i = 0; i < Nwin; i++) drive(1'b1, i);
        drive(1'b0, 0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(bus.dv_out && bus.index == Iwidth'(10)) && w < 100);
        check("mid_found", 64'(w < 100), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_dv", bus.dv_out, 1'b0);
        check("mid_dout", {bus.dout_real, bus.dout_imag}, '0);
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < Nwin - 1; i++) drive(1'b1, 1000 + i);
        drive(1'b0, 0);
        repeat (20) @(posedge clk);
        check("mid_quiet", 64'(frames), 64'd0);
        drive(1'b1, 1000 + Nwin - 1);
        drive(1'b0, 0);
        drain("mid");
        check("mid_frames", 64'(frames), 64'd1);

        // Non-overlapping configuration on the second instance.
        do_reset();
        for (int i = 0; i < 3 * Nwin; i++) drive2(1'b1, i);
        drive2(1'b0, 0);
        drain("hop32");
        check("hop32_frames", 64'(frames2), 64'd3);
        check("hop32_ovf", bus2.overflow, 1'b0);
        check("hop32_main_idle", 64'(frames), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/win_framer.md
Name: win_framer

Overview:
- Upstream neighbour of the window multiplier. Accepts a gappy stream of complex samples.
- Buffers the samples and emits overlapping frames of Nwin samples, oldest first, one sample per cycle.
- Each emitted sample carries a 0..Nwin-1 index, so the output connects directly to the window stage's dv_in/index/din_* inputs.
- A new frame is issued every Nhop input samples once the first Nwin samples have arrived.

Parameters:
- Dwidth, 16, sample component width (two's complement, passed through unchanged).
- Nwin, 32, frame length; must be a power of two.
- Iwidth, 5, index width; must equal log2(Nwin).
- Nhop, 16, new input samples between frame starts; 1 <= Nhop <= Nwin.

Ports:
- clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- dv_in  in  1  input sample valid.
- din_real  in  Dwidth  input real part.
- din_imag  in  Dwidth  input imaginary part.
- dv_out  out  1  output sample valid.
- index  out  Iwidth  position of the output sample within its frame.
- sof  out  1  high with index==0 (start of frame).
- dout_real  out  Dwidth  output real part.
- dout_imag  out  Dwidth  output imaginary part.
- overflow  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync deassert assumed):
  - dv_out=0, sof=0, index=0, dout_*=0, overflow=0.
  - State=FILL; write pointer wp=0, sample count=0, hop count=0, no pending frame.
  - Buffer contents are don't-care.
- Buffer:
  - Simple dual-port, depth 2*Nwin, address width Iwidth+1.
  - Write at wp on dv_in, then wp increments mod 2*Nwin.
  - Synchronous read, 1-cycle read latency.
- Frame trigger (evaluated on the cycle a sample is written):
  - FILL: count samples; the Nwin-th sample raises a trigger and resets the hop count to 0. State then leaves FILL permanently (until reset).
  - After FILL: the hop count increments per sample; on reaching Nhop it raises a trigger and returns to 0.
  - Trigger start address = (wp_after_write - Nwin) mod 2*Nwin, i.e. the oldest of the last Nwin samples.
- State machine:
  - FILL: wait for the first trigger.
  - IDLE: no frame active.
  - READ: issue Nwin read addresses, start+0 .. start+Nwin-1, one per cycle, with a read counter 0..Nwin-1.
  - FILL or IDLE + trigger -> READ on the next cycle; the start address is latched.
  - READ on the last address (counter==Nwin-1):
    - pending set -> READ, reload start from pending, clear pending, no idle gap;
    - otherwise -> IDLE.
  - Trigger during READ with pending empty: latch into pending.
  - Trigger during READ with pending full: drop the trigger, set overflow.
  - A trigger coinciding with the last READ cycle while pending is full is dropped and sets overflow.
- Output timing:
  - Output valid in cycle t+2, where cycle t is the READ cycle issuing address start+k. Registered after the RAM.
  - dv_out=1, index=k, sof=(k==0), dout_* = sample written at start+k.
  - Latency from the triggering write to the first dv_out is 3 cycles.
  - Back-to-back frames produce contiguous dv_out with index wrapping Nwin-1 -> 0.
- Rate contract: the input duty cycle must be <= Nhop/Nwin. Under the contract no unread sample is overwritten. The block does not detect overwrites beyond the pending-queue overflow.
- Writes and reads to different addresses in the same cycle are legal. Same-address collision cannot occur under the contract; RAM read-during-write behaviour is don't-care.
- Reset mid-frame: output stops immediately (dv_out=0), and buffering restarts in FILL.
- With Nhop=Nwin, frames are non-overlapping and each input sample is emitted exactly once.

Decomposition:
- Package win_pkg:
  - Default constants Dwidth, Nwin, Iwidth, Nhop.
  - State enum typedef {FILL, IDLE, READ}.
  - Complex sample struct typedef {real, imag}.
- Sub-module win_framer_ram: parameterised simple dual-port synchronous RAM, depth 2*Nwin, width 2*Dwidth, no reset on the array.

Test Plan:
- Fill, full rate:
  - Stimulus: dv_in=1 for 32 cycles, din_real=0..31, din_imag=-(0..31).
  - Required: dv_out high 32 consecutive cycles starting 3 cycles after the 32nd write; index 0..31; dout_real 0..31; sof only on index 0; overflow=0.
- Overlap, contract rate:
  - Stimulus: after the fill, samples 32..63 with dv_in every 2nd cycle.
  - Required: frames start with samples 16 and 32, containing 16..47 and 32..63; overflow=0.
- Back-to-back pending:
  - Stimulus: after the fill, 16 samples at full rate.
  - Required: the second frame (16..47) follows the first with no dv_out gap; overflow=0.
- Overflow:
  - Stimulus: continuous full-rate input for 100 samples.
  - Required: overflow asserts on the first trigger seen with pending full and stays 1; dv_out never shows an index discontinuity within a frame.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 at index 10, then release.
  - Required: same cycle, dv_out=0 and dout_*=0. After release, no dv_out until 32 new samples are written, then a frame containing only the new samples.
- Nhop=Nwin=32 configuration:
  - Stimulus: 96 samples, 0..95.
  - Required: exactly 3 frames (0..31, 32..63, 64..95), no sample repeated.
